opcode_sequencer: RTL and testbench
===================================

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- instr_op_i  in  5  opcode of the fetched instruction.
- instr_valid_i  in  1  fetched opcode is present.
- instr_ready_o  out  1  combinational; fetched opcode is consumed this cycle.
- stall_i  in  1  hazard stall; insert a bubble and hold.
- flush_i  in  1  branch taken; discard the fetched opcode.
- int_req_i  in  1  one-cycle interrupt request pulse.
- op_o  out  5  registered opcode to the control unit.
- bubble_o  out  1  registered makeMeBubble to the control unit.
- int_ack_o  out  1  registered one-cycle acknowledge.
- illegal_o  out  1  sticky illegal-opcode flag.

Function
REQ-003 op_o and bubble_o SHALL be registered, with a latency of 1 cycle from the decision to the output.
REQ-004 The state machine SHALL have exactly these states: NORMAL, CALL2, RET2, RTI2, INT1, INT2.
REQ-005 In NORMAL, the first matching case in this list SHALL apply:
- flush_i: bubble.
- stall_i: bubble.
- interrupt pending: go to INT1, bubble.
- instr_valid_i: issue instr_op_i.
- otherwise: bubble.
REQ-006 A bubble SHALL drive bubble_o=1 and op_o=00000.
REQ-007 instr_ready_o SHALL be 1 only when in NORMAL and (flush_i, or (!stall_i and no interrupt pending and instr_valid_i)); a flush consumes (discards) the fetched opcode.
REQ-008 Issuing 11000 (CALL), 11010 (RET) or 11100 (RTI) SHALL move to CALL2, RET2 or RTI2 respectively.
REQ-009 CALL2, RET2 and RTI2 SHALL issue 11001, 11011 and 11101 respectively for one cycle, then return to NORMAL.
REQ-010 INT1 SHALL issue 11110 and clear the pending flag.
REQ-011 INT2 SHALL issue 11111, pulse int_ack_o, and then go to NORMAL.
REQ-012 stall_i in CALL2, RET2, RTI2, INT1 or INT2 SHALL output a bubble and hold the state.
REQ-013 flush_i SHALL be ignored in CALL2, RET2, RTI2, INT1 and INT2, so that a multi-part sequence is never split.
REQ-014 An int_req_i pulse SHALL set the pending flag in any state.
REQ-015 Only one interrupt SHALL be pending at a time; extra pulses while pending are merged.
REQ-016 A pending interrupt SHALL be taken only in NORMAL, so it waits until any second part has been issued.
REQ-017 An int_req_i pulse in the same cycle that INT1 clears the flag SHALL leave the flag set, and that interrupt is serviced after INT2.
REQ-018 Fetched opcodes 11001, 11011, 11101, 11110 and 11111 are internal-only and SHALL be illegal; their handling is given in REQ-021.

Reset
REQ-019 While rst_n=0, the block SHALL hold: state=NORMAL, op_o=00000, bubble_o=1, int_ack_o=0, illegal_o=0, pending=0.
REQ-020 Reset asserted mid-sequence (for example in CALL2 or INT1) SHALL abort the sequence immediately and drop any pending interrupt.

Configuration
REQ-021 Macro OPSEQ_ILLEGAL_TRAP_EN SHALL select illegal-opcode handling:
- Defined: an illegal opcode is consumed, output as a bubble, and sets illegal_o, which stays set until reset.
- Undefined: an illegal opcode is consumed and issued as 00000 with bubble_o=0, and illegal_o is tied to 0.

Structure
REQ-022 A shared package opseq_pkg SHALL hold:
- the 5-bit opcode constants for NOP, CALL, CALL2, RET, RET2, RTI, RTI2, INT1 and INT2;
- the state enum type.
REQ-023 The block SHALL be a single module with no sub-module; the pending latch and the state machine are inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Valid 11000 with no stall -> op_o=11000, then 11001 on the next cycle; instr_ready_o=0 during the CALL2 decision cycle.
- int_req_i pulse while in RET2 -> 11011 is issued, then 11110, then 11111 with int_ack_o=1, then normal fetch resumes.
- stall_i=1 for 2 cycles in CALL2 -> 2 bubbles (bubble_o=1, op_o=00000), then 11001.
- flush_i and instr_valid_i both 1 with op 01001 in NORMAL -> instr_ready_o=1, a bubble is issued, and 01001 is never issued.
- Fetched 11111 -> with the macro: bubble and illegal_o=1, held sticky; without the macro: op_o=00000, bubble_o=0, illegal_o=0.
- rst_n low in INT1 with an interrupt pending -> the REQ-019 values; no int_ack_o after release.

Source files
------------

// File: rtl/opseq_pkg.sv
// Shared opcode constants and state type for the opcode sequencer.
// Two-part opcodes use their base value with bit 0 set for the second part.
package opseq_pkg;

   localparam logic [4:0] OpNop   = 5'b00000;
   localparam logic [4:0] OpCall  = 5'b11000;
   localparam logic [4:0] OpCall2 = 5'b11001;
   localparam logic [4:0] OpRet   = 5'b11010;
   localparam logic [4:0] OpRet2  = 5'b11011;
   localparam logic [4:0] OpRti   = 5'b11100;
   localparam logic [4:0] OpRti2  = 5'b11101;
   localparam logic [4:0] OpInt1  = 5'b11110;
   localparam logic [4:0] OpInt2  = 5'b11111;

   typedef enum logic [2:0] {
      StNormal,
      StCall2,
      StRet2,
      StRti2,
      StInt1,
      StInt2
   } state_e;

   // Opcodes that only the sequencer itself may generate.
   function automatic logic is_internal_op(input logic [4:0] op);
      return (op == OpCall2) || (op == OpRet2) || (op == OpRti2) ||
             (op == OpInt1)  || (op == OpInt2);
   endfunction

endpackage

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: expands CALL/RET/RTI into two parts and injects interrupt sequences.
// Define OPSEQ_ILLEGAL_TRAP_EN to turn illegal opcodes into bubbles with a sticky illegal_o.
module opcode_sequencer
   import opseq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] instr_op_i,
   input  logic       instr_valid_i,
   output logic       instr_ready_o,
   input  logic       stall_i,
   input  logic       flush_i,
   input  logic       int_req_i,
   output logic [4:0] op_o,
   output logic       bubble_o,
   output logic       int_ack_o,
   output logic       illegal_o
);

   state_e     r_state;
   logic [4:0] r_op;
   logic       r_bubble;
   logic       r_int_ack;
   logic       r_pend;
`ifdef OPSEQ_ILLEGAL_TRAP_EN
   logic       r_illegal;
`endif

   logic w_in_normal;

   assign w_in_normal   = (r_state == StNormal);
   // A flush consumes the fetched opcode even though nothing is issued.
   assign instr_ready_o = w_in_normal &&
                          (flush_i || (!stall_i && !r_pend && instr_valid_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StNormal;
         r_op      <= OpNop;
         r_bubble  <= 1'b1;
         r_int_ack <= 1'b0;
         r_pend    <= 1'b0;
`ifdef OPSEQ_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         r_op      <= OpNop;
         r_bubble  <= 1'b1;
         r_int_ack <= 1'b0;
         if (int_req_i) r_pend <= 1'b1;
         case (r_state)
            StNormal: begin
               if (!flush_i && !stall_i) begin
                  if (r_pend) begin
                     r_state <= StInt1;
                  end else if (instr_valid_i) begin
                     if (is_internal_op(instr_op_i)) begin
`ifdef OPSEQ_ILLEGAL_TRAP_EN
                        r_illegal <= 1'b1;
`else
                        r_bubble  <= 1'b0;
`endif
                     end else begin
                        r_op     <= instr_op_i;
                        r_bubble <= 1'b0;
                        case (instr_op_i)
                           OpCall:  r_state <= StCall2;
                           OpRet:   r_state <= StRet2;
                           OpRti:   r_state <= StRti2;
                           default: r_state <= StNormal;
                        endcase
                     end
                  end
               end
            end
            StCall2: if (!stall_i) begin
               r_op     <= OpCall2;
               r_bubble <= 1'b0;
               r_state  <= StNormal;
            end
            StRet2: if (!stall_i) begin
               r_op     <= OpRet2;
               r_bubble <= 1'b0;
               r_state  <= StNormal;
            end
            StRti2: if (!stall_i) begin
               r_op     <= OpRti2;
               r_bubble <= 1'b0;
               r_state  <= StNormal;
            end
            StInt1: if (!stall_i) begin
               r_op     <= OpInt1;
               r_bubble <= 1'b0;
               r_state  <= StInt2;
               // A request arriving as the flag clears becomes the next pending interrupt.
               r_pend   <= int_req_i;
            end
            StInt2: if (!stall_i) begin
               r_op      <= OpInt2;
               r_bubble  <= 1'b0;
               r_int_ack <= 1'b1;
               r_state   <= StNormal;
            end
            default: r_state <= StNormal;
         endcase
      end
   end

   assign op_o      = r_op;
   assign bubble_o  = r_bubble;
   assign int_ack_o = r_int_ack;
`ifdef OPSEQ_ILLEGAL_TRAP_EN
   assign illegal_o = r_illegal;
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_sequencer.sv
// Bench for opcode_sequencer: directed scenarios plus random traffic against a queue-based model.
// Honours OPSEQ_ILLEGAL_TRAP_EN the same way as the design.
module tb_opcode_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] instr_op_i = '0;
   logic       instr_valid_i = 1'b0;
   logic       instr_ready_o;
   logic       stall_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       int_req_i = 1'b0;
   logic [4:0] op_o;
   logic       bubble_o;
   logic       int_ack_o;
   logic       illegal_o;

   opcode_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_op_i   (instr_op_i),
      .instr_valid_i(instr_valid_i),
      .instr_ready_o(instr_ready_o),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .int_req_i    (int_req_i),
      .op_o         (op_o),
      .bubble_o     (bubble_o),
      .int_ack_o    (int_ack_o),
      .illegal_o    (illegal_o)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Model state: opcodes still owed by a multi-part sequence, pending flag, sticky illegal.
   logic [4:0] m_q[$];
   logic       m_pend = 1'b0;
   logic       m_ill  = 1'b0;
   logic       s_ready;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic is_illegal(input logic [4:0] op);
      return op inside {5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
   endfunction

   // Apply one cycle of inputs at the falling edge, check ready, then outputs after the rising edge.
   task automatic step(input logic v, input logic [4:0] op, input logic st, input logic fl,
                       input logic ir);
      logic [4:0] e_op;
      logic       e_bub, e_ack, e_rdy, n_pend;
      logic [4:0] x;
      instr_valid_i = v;
      instr_op_i    = op;
      stall_i       = st;
      flush_i       = fl;
      int_req_i     = ir;
      #1;
      s_ready = instr_ready_o;
      e_rdy   = (m_q.size() == 0) && (fl || (!st && !m_pend && v));
      check("ready", 32'(instr_ready_o), 32'(e_rdy));
      e_op   = 5'b00000;
      e_bub  = 1'b1;
      e_ack  = 1'b0;
      n_pend = m_pend;
      if (m_q.size() == 0) begin
         if (!fl && !st) begin
            if (m_pend) begin
               m_q.push_back(5'b11110);
               m_q.push_back(5'b11111);
            end else if (v) begin
               if (is_illegal(op)) begin
`ifdef OPSEQ_ILLEGAL_TRAP_EN
                  m_ill = 1'b1;
`else
                  e_bub = 1'b0;
`endif
               end else begin
                  e_op  = op;
                  e_bub = 1'b0;
                  if (op == 5'b11000 || op == 5'b11010 || op == 5'b11100)
                     m_q.push_back(op + 5'd1);
               end
            end
         end
      end else if (!st) begin
         x     = m_q.pop_front();
         e_op  = x;
         e_bub = 1'b0;
         if (x == 5'b11110) n_pend = 1'b0;
         if (x == 5'b11111) e_ack = 1'b1;
      end
      if (ir) n_pend = 1'b1;
      m_pend = n_pend;
      @(posedge clk);
      #1;
      check("op", 32'(op_o), 32'(e_op));
      check("bubble", 32'(bubble_o), 32'(e_bub));
      check("int_ack", 32'(int_ack_o), 32'(e_ack));
      check("illegal", 32'(illegal_o), 32'(m_ill));
      int_req_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      instr_valid_i = 1'b0;
      stall_i       = 1'b0;
      flush_i       = 1'b0;
      int_req_i     = 1'b0;
      #1;
      check("rst_op", 32'(op_o), 32'h0);
      check("rst_bubble", 32'(bubble_o), 32'h1);
      check("rst_ack", 32'(int_ack_o), 32'h0);
      check("rst_illegal", 32'(illegal_o), 32'h0);
      m_q.delete();
      m_pend = 1'b0;
      m_ill  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] ill_ops [5];
      logic [4:0] op;
      int         r;
      ill_ops = '{5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
      @(negedge clk);
      do_reset();

      // CALL expands into CALL then CALL2; ready drops while CALL2 is decided.
      step(1'b1, 5'b11000, 1'b0, 1'b0, 1'b0);
      check("call_op", 32'(op_o), 32'h18);
      step(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
      check("call2_ready", 32'(s_ready), 32'h0);
      check("call2_op", 32'(op_o), 32'h19);

      // Interrupt raised during RET2 waits for RET2, then INT1/INT2 with ack.
      step(1'b1, 5'b11010, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
      check("ret2_op", 32'(op_o), 32'h1b);
      idle();
      idle();
      check("int1_op", 32'(op_o), 32'h1e);
      idle();
      check("int2_op", 32'(op_o), 32'h1f);
      check("int2_ack", 32'(int_ack_o), 32'h1);
      step(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
      check("resume_op", 32'(op_o), 32'h05);

      // Two stalled cycles in CALL2 hold the second part back.
      step(1'b1, 5'b11000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
      check("stall_bubble", 32'(bubble_o), 32'h1);
      idle();
      check("stall_call2", 32'(op_o), 32'h19);

      // Flush discards the fetched opcode.
      step(1'b1, 5'b01001, 1'b0, 1'b1, 1'b0);
      check("flush_ready", 32'(s_ready), 32'h1);
      check("flush_bubble", 32'(bubble_o), 32'h1);
      idle();
      check("flush_not_issued", 32'(op_o == 5'b01001), 32'h0);

      // Internal-only opcode fetched from outside.
      step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
`ifdef OPSEQ_ILLEGAL_TRAP_EN
      check("ill_bubble", 32'(bubble_o), 32'h1);
      check("ill_flag", 32'(illegal_o), 32'h1);
      idle();
      check("ill_sticky", 32'(illegal_o), 32'h1);
`else
      check("ill_op", 32'(op_o), 32'h0);
      check("ill_bubble", 32'(bubble_o), 32'h0);
      check("ill_flag", 32'(illegal_o), 32'h0);
`endif

      // Reset while in INT1 with another interrupt pending.
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle();
         check("post_rst_ack", 32'(int_ack_o), 32'h0);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       op = 5'b11000;
            1:       op = 5'b11010;
            2:       op = 5'b11100;
            3:       op = ill_ops[$urandom_range(0, 4)];
            default: op = 5'($urandom);
         endcase
         if ($urandom_range(0, 299) == 0) do_reset();
         step(($urandom_range(0, 3) != 0), op, ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
